// File: rtl/coin_pkg.sv
// Shared coin definitions for the change dispenser and the main coin-counting controller.
package coin_pkg;

  typedef enum logic [1:0] {
    PENNY   = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_type_t;

  localparam int unsigned COIN_VALUE_PENNY   = 1;
  localparam int unsigned COIN_VALUE_NICKEL  = 5;
  localparam int unsigned COIN_VALUE_DIME    = 10;
  localparam int unsigned COIN_VALUE_QUARTER = 25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_OFFER  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } disp_state_t;

  function automatic int unsigned coin_value_of(coin_type_t t);
    case (t)
      QUARTER: return COIN_VALUE_QUARTER;
      DIME:    return COIN_VALUE_DIME;
      NICKEL:  return COIN_VALUE_NICKEL;
      default: return COIN_VALUE_PENNY;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin request handshake between the change dispenser (master) and the hopper driver (slave).
interface change_dispenser_if;
  import coin_pkg::*;

  logic       coin_valid;
  coin_type_t coin_type;
  logic       coin_ready;

  modport master (output coin_valid, output coin_type, input coin_ready);
  modport slave  (input coin_valid, input coin_type, output coin_ready);

endinterface

// File: rtl/coin_select.sv
// Greedy coin selector: largest coin not exceeding the amount, plus that coin's value.
module coin_select
  import coin_pkg::*;
#(
  parameter int BAL_W = 7
) (
  input  logic [BAL_W-1:0] amount,
  output coin_type_t       coin_type,
  output logic [BAL_W-1:0] coin_value
);

  always_comb begin
    coin_type = PENNY;
    if (amount >= BAL_W'(COIN_VALUE_QUARTER))
      coin_type = QUARTER;
    else if (amount >= BAL_W'(COIN_VALUE_DIME))
      coin_type = DIME;
    else if (amount >= BAL_W'(COIN_VALUE_NICKEL))
      coin_type = NICKEL;
  end

  assign coin_value = BAL_W'(coin_value_of(coin_type));

endmodule

// File: rtl/change_dispenser.sv
// Returns a snapshotted balance as greedy coin requests with a recovery gap after each coin.
// Optional abort input enabled by defining CHANGE_DISPENSER_ABORT_EN.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int BAL_W      = 7,
  parameter int GAP_CYCLES = 4
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset_n,
  input  logic               start,
  input  logic [BAL_W-1:0]   balance_in,
`ifdef CHANGE_DISPENSER_ABORT_EN
  input  logic               abort,
`endif
  change_dispenser_if.master coin,
  output logic               busy,
  output logic               done,
  output logic [BAL_W-1:0]   remaining,
  output logic [4:0]         coin_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  disp_state_t      state;
  logic [GAP_W-1:0] gap_cnt;
  logic             coin_valid_q;
  coin_type_t       coin_type_q;
  logic [BAL_W-1:0] coin_val_q;
  coin_type_t       sel_type;
  logic [BAL_W-1:0] sel_value;
  logic             abort_req;
  logic             in_txn;

`ifdef CHANGE_DISPENSER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_txn = (state == ST_SELECT) || (state == ST_OFFER) || (state == ST_GAP);

  coin_select #(.BAL_W(BAL_W)) u_select (
    .amount     (remaining),
    .coin_type  (sel_type),
    .coin_value (sel_value)
  );

  assign coin.coin_valid = coin_valid_q;
  assign coin.coin_type  = coin_type_q;

  // The coin value is latched alongside its type so the subtraction in OFFER
  // never depends on a selector output that could move with remaining.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      coin_valid_q <= 1'b0;
      coin_type_q  <= PENNY;
      coin_val_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      remaining    <= '0;
      coin_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining  <= balance_in;
            coin_count <= '0;
            busy       <= 1'b1;
            state      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            coin_type_q  <= sel_type;
            coin_val_q   <= sel_value;
            coin_valid_q <= 1'b1;
            state        <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (coin_valid_q && coin.coin_ready) begin
            remaining    <= remaining - coin_val_q;
            if (coin_count != 5'd31)
              coin_count <= coin_count + 5'd1;
            coin_valid_q <= 1'b0;
            gap_cnt      <= GAP_W'(GAP_CYCLES - 1);
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0)
            state <= ST_SELECT;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          coin_valid_q <= 1'b0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase

      // Abort wins over the normal next state but keeps any coincident handshake above.
      if (abort_req && in_txn) begin
        coin_valid_q <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        state        <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequencer that returns a coin-counter balance as change, one coin at a time. It sits between the balance register of the main coin-counting controller and the coin-hopper driver. On a start request it snapshots the balance, then greedily issues quarter/dime/nickel/penny requests over a valid/ready handshake until the balance reaches zero. A fixed gap is inserted between coins so the mechanical hopper can recover.

## Interface
Clocking is fixed: one clock; reset is asynchronous and active-low.

Parameters:
- BAL_W, 7: balance width in cents (max 127).
- GAP_CYCLES, 4: idle cycles after each accepted coin (≥1).

Ports:
- MAX10_CLK1_50  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to dispense change.
- balance_in  in  BAL_W  balance to return, sampled with start.
- coin_valid  out  1  coin request to hopper.
- coin_type  out  2  0=penny, 1=nickel, 2=dime, 3=quarter.
- coin_ready  in  1  hopper accepts the current coin.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the balance reaches zero.
- remaining  out  BAL_W  balance not yet dispensed.
- coin_count  out  5  coins accepted in the current/last transaction.

## Operation
- States: IDLE, SELECT, OFFER, GAP, FINISH.
- IDLE: start=1 → remaining←balance_in, coin_count←0, go to SELECT. Otherwise hold.
- SELECT: if remaining==0 → FINISH. Otherwise coin_type ← largest coin with value ≤ remaining (25/10/5/1), go to OFFER.
- OFFER: coin_valid=1, coin_type held stable.
  - On coin_valid&&coin_ready: remaining ← remaining − value, coin_count+1, go to GAP.
  - No timeout.
- GAP: count GAP_CYCLES cycles, then SELECT.
- FINISH: done=1 for exactly one cycle, then IDLE. remaining and coin_count hold their final values until the next start.
- start outside IDLE is ignored, including start in the FINISH cycle.
- Arithmetic: subtraction never underflows because the selected value is always ≤ remaining. coin_count saturates at 31.

## Timing
- Reset values: state=IDLE, coin_valid=0, coin_type=0, busy=0, done=0, remaining=0, coin_count=0.
- Reset is asynchronous at any point, including mid-OFFER with coin_valid high. Outputs clear immediately and no coin is counted.
- busy rises the cycle after start is sampled.
- Zero balance: start at cycle T → SELECT at T+1 → done at T+2. No coin_valid ever asserted.
- First coin_valid appears 2 cycles after start is sampled.
- Handshake completes on the edge where both coin_valid and coin_ready are high; coin_valid drops the next cycle.
- Per-coin period = 1 (SELECT) + OFFER wait (≥1) + GAP_CYCLES.
- coin_ready while coin_valid=0 has no effect.

## Configuration
- CHANGE_DISPENSER_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 in SELECT, OFFER or GAP → IDLE next cycle; coin_valid drops, done is not pulsed, remaining keeps the undispensed amount.
  - A handshake that coincides with abort is still counted and subtracted before the return to IDLE.
- Macro undefined: no abort port; a transaction always runs to FINISH.

## Structure
- Shared package coin_pkg:
  - coin_type_t enum (PENNY, NICKEL, DIME, QUARTER).
  - COIN_VALUE constants (1, 5, 10, 25).
  - Dispenser state enum.
- Sub-module coin_select: combinational greedy selector mapping remaining to coin_type and coin value. It is reused by the main controller for the LED coin display.

## Test plan
- balance_in=41, coin_ready tied 1 → coins QUARTER, DIME, NICKEL, PENNY in order; remaining 41→16→6→1→0; coin_count=4; single done pulse.
- balance_in=0 → done 2 cycles after start; coin_valid never high; coin_count=0.
- balance_in=30, coin_ready low for 5 cycles in the first OFFER → coin_valid and coin_type=QUARTER held for all 5 cycles; then QUARTER, NICKEL; remaining=0.
- start pulsed again mid-transaction with balance_in=99 → ignored; original 41 sequence completes unchanged.
- reset_n low during second OFFER of balance 41 → all outputs reset asynchronously; a fresh start with 7 yields NICKEL, PENNY, PENNY.
- With CHANGE_DISPENSER_ABORT_EN: balance 41, abort in GAP after the first coin → IDLE, remaining=16, coin_count=1, no done pulse.
